// File: rtl/gfx256_wbm_writer.sv
// Wishbone classic write master for 256-bit renderer requests: one bus cycle per request,
// bounded retry on wbm_err_i, optional timeout, guaranteed single ack_o pulse, sticky fault flags.
module gfx256_wbm_writer #(
  parameter int TIMEOUT = 1023,
  parameter int RETRIES = 1,
  parameter int TO_W    = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         write_i,
  input  logic [31:0]  render_addr_i,
  input  logic [31:0]  render_sel_i,
  input  logic [255:0] render_dat_i,
  output logic         ack_o,
  output logic         busy_o,
  output logic         wbm_cyc_o,
  output logic         wbm_stb_o,
  output logic         wbm_we_o,
  output logic [31:0]  wbm_adr_o,
  output logic [31:0]  wbm_sel_o,
  output logic [255:0] wbm_dat_o,
  input  logic         wbm_ack_i,
  input  logic         wbm_err_i,
  input  logic         err_clr_i,
  output logic         err_o,
  output logic         ovf_o
);

  // Handshake: a request is accepted on any edge where write_i=1 and the FSM is IDLE; it is
  // always answered by exactly one ack_o pulse. write_i seen while busy is dropped and flagged in ovf_o.
  typedef enum logic [1:0] {IDLE, BUS, GAP} state_t;

  state_t          state_q;
  logic [3:0]      retry_q;
  logic [TO_W-1:0] to_cnt_q;
  logic            ack_q, busy_q, cyc_q, stb_q, we_q, err_q, ovf_q;
  logic [31:0]     adr_q, sel_q;
  logic [255:0]    dat_q;
  logic            to_hit;

  assign to_hit = (TIMEOUT != 0) && (to_cnt_q == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      retry_q  <= 4'd0;
      to_cnt_q <= '0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      adr_q    <= 32'd0;
      sel_q    <= 32'd0;
      dat_q    <= 256'd0;
    end else begin
      ack_q <= 1'b0;
      // Clear first so that a set event later in this block takes priority.
      if (err_clr_i) begin
        err_q <= 1'b0;
        ovf_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (write_i) begin
            adr_q    <= {render_addr_i[31:5], 5'b0};
            sel_q    <= render_sel_i;
            dat_q    <= render_dat_i;
            retry_q  <= 4'd0;
            to_cnt_q <= '0;
            cyc_q    <= 1'b1;
            stb_q    <= 1'b1;
            we_q     <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= BUS;
          end
        end
        BUS: begin
          if (write_i) ovf_q <= 1'b1;
          if (wbm_err_i) begin
            cyc_q <= 1'b0;
            stb_q <= 1'b0;
            we_q  <= 1'b0;
            if (retry_q == 4'(RETRIES)) begin
              err_q   <= 1'b1;
              ack_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              retry_q <= retry_q + 4'd1;
              state_q <= GAP;
            end
          end else if (wbm_ack_i) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            ack_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (to_hit) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b1;
            ack_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (to_cnt_q != '1) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        GAP: begin
          if (write_i) ovf_q <= 1'b1;
          cyc_q    <= 1'b1;
          stb_q    <= 1'b1;
          we_q     <= 1'b1;
          to_cnt_q <= '0;
          state_q  <= BUS;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          cyc_q   <= 1'b0;
          stb_q   <= 1'b0;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign ack_o     = ack_q;
  assign busy_o    = busy_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_adr_o = adr_q;
  assign wbm_sel_o = sel_q;
  assign wbm_dat_o = dat_q;
  assign err_o     = err_q;
  assign ovf_o     = ovf_q;

endmodule
